// File: rtl/seg14_scroll_mux.sv
// rtl/seg14_scroll_mux.sv - multiplexed 14-segment driver with message RAM and scrolling (option: SEG14_BLINK_EN)
module seg14_scroll_mux #(
  parameter int NDIG    = 12,
  parameter int DEPTH   = 32,
  parameter int DIG_DIV = 1,
  localparam int AW = $clog2(DEPTH),
`ifdef SEG14_BLINK_EN
  localparam int CW = 7
`else
  localparam int CW = 6
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [CW-1:0]   wr_data,
  input  logic [AW:0]     msg_len,
  input  logic            scroll_en,
  input  logic [7:0]      scroll_div,
  output logic [NDIG-1:0] sel,
  output logic [13:0]     segm,
  output logic            frame_tick
);

  localparam int DW = $clog2(NDIG);
  localparam logic [15:0]     DIV_LAST = 16'(DIG_DIV - 1);
  localparam logic [DW-1:0]   DIG_LAST = DW'(NDIG - 1);
  localparam logic [NDIG-1:0] ONE      = NDIG'(1);

  // Segment order, bit 13 down to 0: a b c d e f g1 g2 h j k l m n
  function automatic logic [13:0] glyph(input logic [5:0] c);
    case (c)
      6'd0:  glyph = 14'b11111100001100;
      6'd1:  glyph = 14'b01100000001000;
      6'd2:  glyph = 14'b11011011000000;
      6'd3:  glyph = 14'b11110001000000;
      6'd4:  glyph = 14'b01100111000000;
      6'd5:  glyph = 14'b10110111000000;
      6'd6:  glyph = 14'b10111111000000;
      6'd7:  glyph = 14'b11100000000000;
      6'd8:  glyph = 14'b11111111000000;
      6'd9:  glyph = 14'b11110111000000;
      6'd10: glyph = 14'b11101111000000; // A
      6'd11: glyph = 14'b11110001010010; // B
      6'd12: glyph = 14'b10011100000000; // C
      6'd13: glyph = 14'b11110000010010; // D
      6'd14: glyph = 14'b10011110000000; // E
      6'd15: glyph = 14'b10001110000000; // F
      6'd16: glyph = 14'b10111101000000; // G
      6'd17: glyph = 14'b01101111000000; // H
      6'd18: glyph = 14'b10010000010010; // I
      6'd19: glyph = 14'b01111000000000; // J
      6'd20: glyph = 14'b00001110001001; // K
      6'd21: glyph = 14'b00011100000000; // L
      6'd22: glyph = 14'b01101100101000; // M
      6'd23: glyph = 14'b01101100100001; // N
      6'd24: glyph = 14'b11111100000000; // O
      6'd25: glyph = 14'b11001111000000; // P
      6'd26: glyph = 14'b11111100000001; // Q
      6'd27: glyph = 14'b11001111000001; // R
      6'd28: glyph = 14'b10110111000000; // S
      6'd29: glyph = 14'b10000000010010; // T
      6'd30: glyph = 14'b01111100000000; // U
      6'd31: glyph = 14'b00001100001100; // V
      6'd32: glyph = 14'b01101100000101; // W
      6'd33: glyph = 14'b00000000101101; // X
      6'd34: glyph = 14'b00000000101010; // Y
      6'd35: glyph = 14'b10010000001100; // Z
      default: glyph = 14'b0;
    endcase
  endfunction

  logic [CW-1:0] buffer [DEPTH];
  logic [15:0]   presc;
  logic [DW-1:0] dig;
  logic [AW-1:0] ptr, offset;
  logic [7:0]    frame_cnt;
  logic [AW:0]   len_q;
  logic          scroll_q;

  logic          step, last_dig, eff_scroll, blank, hide;
  logic [AW:0]   eff_len;
  logic [AW-1:0] eff_off, cur, next_ptr, next_off;
  logic [CW-1:0] ch;

  assign step     = (presc == DIV_LAST);
  assign last_dig = (dig == DIG_LAST);

  // Message RAM: plain registers, no reset, read is combinational so a same-edge write is seen one slot later
  always_ff @(posedge clk) begin
    if (wr_en) buffer[wr_addr] <= wr_data;
  end

  // Slot decode: at digit 0 the live length/mode are used and the start offset is sanitised
  always_comb begin
    eff_len    = len_q;
    eff_scroll = scroll_q;
    eff_off    = offset;
    cur        = ptr;
    if (dig == '0) begin
      eff_len    = msg_len;
      eff_scroll = scroll_en;
      if (!scroll_en || (msg_len <= {1'b0, offset})) eff_off = '0;
      cur = eff_off;
    end
    ch       = buffer[cur];
    blank    = (eff_len == '0) || (!eff_scroll && (32'(dig) >= 32'(eff_len)));
    next_ptr = ({1'b0, cur} == eff_len - 1'b1) ? '0 : cur + 1'b1;
    next_off = ({1'b0, offset} == len_q - 1'b1) ? '0 : offset + 1'b1;
  end

`ifdef SEG14_BLINK_EN
  logic [4:0] blink_cnt;
  logic       blink_phase;

  // Blink phase flips every 32 frames
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (step && last_dig) begin
      blink_cnt <= blink_cnt + 1'b1;
      if (blink_cnt == 5'd31) blink_phase <= ~blink_phase;
    end
  end

  assign hide = blank || (blink_phase && ch[6]);
`else
  assign hide = blank;
`endif

  // Digit scan, character pointer and scroll offset; all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= '0;
      segm       <= '0;
      frame_tick <= 1'b0;
      presc      <= '0;
      dig        <= '0;
      ptr        <= '0;
      offset     <= '0;
      frame_cnt  <= '0;
      len_q      <= '0;
      scroll_q   <= 1'b0;
    end else begin
      frame_tick <= step && last_dig;
      presc      <= step ? '0 : presc + 1'b1;
      if (step) begin
        sel  <= ONE << dig;
        segm <= hide ? 14'b0 : glyph(ch[5:0]);
        dig  <= last_dig ? '0 : dig + 1'b1;
        ptr  <= next_ptr;
        if (dig == '0) begin
          len_q    <= msg_len;
          scroll_q <= scroll_en;
          offset   <= eff_off;
          if (!scroll_en) frame_cnt <= '0;
        end
        if (last_dig && scroll_q) begin
          if (frame_cnt == scroll_div) begin
            frame_cnt <= '0;
            offset    <= next_off;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule
